// File: rtl/evo_xb_pmux_arb.sv
// evo_xb_pmux_arb: round-robin pin-ownership arbiter for one PMUX port.
// Serialises pin-ownership requests, rejects overlaps with pins owned by
// other requesters and keeps the ownership table that drives port_x_en_i.
module evo_xb_pmux_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PIN_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*PIN_WIDTH-1:0]   req_mask_i,
  input  logic [NUM_REQ-1:0]             rel_i,
  output logic [NUM_REQ-1:0]             ack_o,
  output logic [NUM_REQ-1:0]             nack_o,
  output logic [NUM_REQ*PIN_WIDTH-1:0]   en_o,
  output logic                           busy_o,
  output logic [7:0]                     conflict_cnt_o
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  ptr_q, ptr_d;
  logic [IW-1:0]                  sel_q, sel_d;
  logic [PIN_WIDTH-1:0]           mask_q, mask_d;
  logic [NUM_REQ*PIN_WIDTH-1:0]   en_q, en_d, en_rel;
  logic [NUM_REQ-1:0]             ack_q, ack_d, nack_q, nack_d;
  logic [7:0]                     cnt_q, cnt_d;

  logic [IW-1:0]                  pick, cand;
  logic                           pick_vld;
  int unsigned                    idx;
  logic [PIN_WIDTH-1:0]           others;
  logic                           grant;
  logic [PIN_WIDTH-1:0]           seen, pin_multi;

  // Round-robin pick: first valid requester at or above the pointer, wrapping
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!pick_vld && req_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Releases apply before the conflict test, so a same-cycle release frees pins
  always_comb begin
    en_rel = en_q;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (rel_i[r]) en_rel[r*PIN_WIDTH +: PIN_WIDTH] = '0;
    end
    others = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (IW'(r) != sel_q) others = others | en_rel[r*PIN_WIDTH +: PIN_WIDTH];
    end
    grant = (mask_q != '0) && ((mask_q & others) == '0);
  end

  // Next-state and next-output logic for the IDLE/EVAL/RESP loop
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    en_d    = en_rel;
    ack_d   = '0;
    nack_d  = '0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d   = pick;
          mask_d  = req_mask_i[pick*PIN_WIDTH +: PIN_WIDTH];
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (grant) begin
          en_d[sel_q*PIN_WIDTH +: PIN_WIDTH] = en_rel[sel_q*PIN_WIDTH +: PIN_WIDTH] | mask_q;
          ack_d[sel_q] = 1'b1;
        end else begin
          nack_d[sel_q] = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        ptr_d = (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
        if ((nack_q != '0) && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      mask_q  <= '0;
      en_q    <= '0;
      ack_q   <= '0;
      nack_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack_o          = ack_q;
  assign nack_o         = nack_q;
  assign en_o           = en_q;
  assign busy_o         = (state_q != IDLE);
  assign conflict_cnt_o = cnt_q;

  // Pins owned by more than one row (must always be empty)
  always_comb begin
    seen      = '0;
    pin_multi = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      pin_multi = pin_multi | (seen & en_q[r*PIN_WIDTH +: PIN_WIDTH]);
      seen      = seen | en_q[r*PIN_WIDTH +: PIN_WIDTH];
    end
  end

  a_excl_owner: assert property (@(posedge clk) disable iff (reset) pin_multi == '0);

endmodule

// File: doc/evo_xb_pmux_arb.md
# evo_xb_pmux_arb

Pin-ownership arbiter for one OpenEvo port's PMUX. Up to NUM_REQ IP blocks request exclusive ownership of sets of port pins; the arbiter serialises the requests round-robin, rejects any that overlap pins owned by another requester, and records the granted ownership. Its enable table drives the port_x_en_i input of evo_xb_pmux directly, so at most one PMUX input is enabled per pin.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters; equals the PMUX MUX_WIDTH of the port
- PIN_WIDTH, 8, pins in the port; equals PORT_x_DWIDTH

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid_i  input  NUM_REQ  per-requester request; held high until that requester's ack or nack
- req_mask_i  input  NUM_REQ*PIN_WIDTH  requested pins; requester r uses bits [r*PIN_WIDTH +: PIN_WIDTH]
- rel_i  input  NUM_REQ  single-cycle pulse; releases every pin owned by that requester
- ack_o  output  NUM_REQ  one-cycle grant pulse
- nack_o  output  NUM_REQ  one-cycle reject pulse
- en_o  output  NUM_REQ*PIN_WIDTH  ownership table; bit r*PIN_WIDTH+p set means requester r owns pin p; connects to port_x_en_i
- busy_o  output  1  high while the FSM is not in IDLE
- conflict_cnt_o  output  8  saturating count of nacks issued

## Operation

- Reset values: en_o=0, ack_o=0, nack_o=0, busy_o=0, conflict_cnt_o=0, round-robin pointer=0, FSM=IDLE.
- FSM states: IDLE, EVAL, RESP.
- IDLE: if any req_valid_i bit is set, select the first set bit at or above the pointer, wrapping modulo NUM_REQ. Latch the selected index and its mask, then go to EVAL. Otherwise stay in IDLE.
- EVAL: compute others = OR of the en_o rows of all requesters except the selected one, after removing rows released in this same cycle.
  - Reject if mask==0, or if (mask & others) != 0.
  - Otherwise grant, and OR the mask into the selected requester's row. Pins the requester already owns do not count as a conflict.
  - Go to RESP.
- RESP: pulse ack_o or nack_o for exactly one cycle. Advance the pointer to (selected+1) mod NUM_REQ. Return to IDLE. On a nack, increment conflict_cnt_o, saturating at 255.
- Release: rel_i[r] clears row r at the next edge, in any FSM state.
  - If release and grant of the same requester land on the same edge, the release is applied first and the grant's mask is then written. The row ends equal to the new mask.
- en_o is updated only at the two points above: the grant edge leaving EVAL and release edges. No other path modifies it.
- Invariant, checked by assertion: for every pin p, at most one row of en_o has bit p set.
- A requester that drops req_valid_i before its response is still answered. The ack or nack is issued against the latched mask.
- req_valid_i and req_mask_i are ignored outside IDLE, except for the mask latched for the selected requester.

## Timing

- Request sampled in IDLE at edge N. EVAL runs during cycle N+1. The table updates and ack_o/nack_o assert in cycle N+2. The FSM is back in IDLE at cycle N+3.
- Throughput: one request per 3 cycles. Back-to-back requests are served in round-robin order with no idle cycle beyond the 3-cycle loop.
- The requester deasserts req_valid_i in the cycle after it sees ack_o or nack_o. If it is still high when sampled in IDLE, the arbiter treats it as a new request.
- rel_i takes effect at the next edge, so en_o reflects the release one cycle after the pulse.
- busy_o is high in EVAL and RESP only.
- Reset asserted mid-transaction aborts the FSM. No ack or nack is issued, and all outputs return to reset values asynchronously.

## Test plan

- Single grant: requester 1 requests mask 0x0F. It receives ack_o=0b0010 three cycles later, and en_o row1=0x0F with all other rows 0.
- Conflict: with row1=0x0F, requester 2 requests 0x18. It receives nack_o=0b0100, en_o is unchanged, and conflict_cnt_o=1. Requester 2 then requests 0xF0 and receives an ack, with row2=0xF0.
- Round-robin fairness: all four requesters request disjoint masks in the same cycle with pointer=0. Acks arrive in order 0,1,2,3, three cycles apart. Repeating with pointer=2 gives order 2,3,0,1.
- Release/grant race: row0=0x03. Requester 0 requests 0x0C while rel_i[0] pulses during its EVAL. The result is an ack and row0=0x0C.
- Zero mask and saturation: a mask=0 request gets a nack. After 300 forced conflicts, conflict_cnt_o=255.
- Reset mid-operation: assert reset during EVAL. No ack or nack is produced, en_o=0, busy_o=0, and the next request after reset is granted normally.
